// File: rtl/rgb2ycbcr_stream.sv
// rgb2ycbcr_stream: 4-stage RGB -> full-range YCbCr converter (BT.709/BT.601).
// One global stall: every stage holds while the output is blocked.
module rgb2ycbcr_stream #(
  parameter int BIT_WIDTH    = 8,
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  localparam int V_BITW = $clog2(FRAME_HEIGHT),
  localparam int H_BITW = $clog2(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [BIT_WIDTH-1:0] in_r,
  input  logic [BIT_WIDTH-1:0] in_g,
  input  logic [BIT_WIDTH-1:0] in_b,
  input  logic [V_BITW-1:0]    in_vcnt,
  input  logic [H_BITW-1:0]    in_hcnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_y,
  output logic [BIT_WIDTH-1:0] out_cb,
  output logic [BIT_WIDTH-1:0] out_cr,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic                 out_mode
);

  localparam int PW = BIT_WIDTH + 13;

  typedef logic signed [PW-1:0] acc_t;
  typedef logic signed [11:0]   coef_t;

  localparam coef_t C709 [9] = '{
    12'sd218,  12'sd732,  12'sd74,
    -12'sd117, -12'sd395, 12'sd512,
    12'sd512,  -12'sd465, -12'sd47
  };
  localparam coef_t C601 [9] = '{
    12'sd306,  12'sd601,  12'sd117,
    -12'sd173, -12'sd339, 12'sd512,
    12'sd512,  -12'sd429, -12'sd83
  };

  localparam acc_t MAXV = acc_t'((1 << BIT_WIDTH) - 1);
  localparam acc_t HALF = acc_t'(1 << (BIT_WIDTH - 1));

  logic adv;
  logic sof;
  logic mode_q;
  logic mode_d;

  logic                 s1_vld_q, s2_vld_q, s3_vld_q;
  logic                 s1_m_q, s2_m_q, s3_m_q;
  logic [V_BITW-1:0]    s1_v_q, s2_v_q, s3_v_q;
  logic [H_BITW-1:0]    s1_h_q, s2_h_q, s3_h_q;
  logic [BIT_WIDTH-1:0] s1_r_q, s1_g_q, s1_b_q;
  acc_t                 s2_p_q [9];
  acc_t                 s3_s_q [3];

  acc_t  px   [3];
  acc_t  prod [9];
  coef_t coef [9];

  assign in_ready = out_ready || !out_valid;
  assign adv      = in_ready;
  assign sof      = in_valid && in_ready &&
                    (in_vcnt == '0) && (in_hcnt == '0);
  // The start-of-frame beat itself already uses the new mode.
  assign mode_d   = sof ? in_mode : mode_q;

  always_comb begin
    px[0] = acc_t'({13'd0, s1_r_q});
    px[1] = acc_t'({13'd0, s1_g_q});
    px[2] = acc_t'({13'd0, s1_b_q});
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        coef[3*k+c] = s1_m_q ? C601[3*k+c] : C709[3*k+c];
        prod[3*k+c] = px[c] * acc_t'(coef[3*k+c]);
      end
    end
  end

  function automatic logic [BIT_WIDTH-1:0] rnd_clip(
    input acc_t s,
    input logic bias
  );
    acc_t t;
    t = (s >>> 9) + acc_t'(1);
    t = t >>> 1;
    if (bias) t = t + HALF;
    if (t[PW-1]) return '0;
    if (t > MAXV) return '1;
    return t[BIT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_m_q    <= 1'b0;
      s1_v_q    <= '0;
      s1_h_q    <= '0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_m_q    <= 1'b0;
      s2_v_q    <= '0;
      s2_h_q    <= '0;
      for (int i = 0; i < 9; i++) s2_p_q[i] <= '0;
      s3_vld_q  <= 1'b0;
      s3_m_q    <= 1'b0;
      s3_v_q    <= '0;
      s3_h_q    <= '0;
      for (int i = 0; i < 3; i++) s3_s_q[i] <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_vcnt  <= '0;
      out_hcnt  <= '0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
    end else begin
      mode_q <= mode_d;
      if (adv) begin
        s1_vld_q  <= in_valid;
        s1_m_q    <= mode_d;
        s1_v_q    <= in_vcnt;
        s1_h_q    <= in_hcnt;
        s1_r_q    <= in_r;
        s1_g_q    <= in_g;
        s1_b_q    <= in_b;

        s2_vld_q  <= s1_vld_q;
        s2_m_q    <= s1_m_q;
        s2_v_q    <= s1_v_q;
        s2_h_q    <= s1_h_q;
        for (int i = 0; i < 9; i++) s2_p_q[i] <= prod[i];

        s3_vld_q  <= s2_vld_q;
        s3_m_q    <= s2_m_q;
        s3_v_q    <= s2_v_q;
        s3_h_q    <= s2_h_q;
        for (int k = 0; k < 3; k++)
          s3_s_q[k] <= s2_p_q[3*k] + s2_p_q[3*k+1] + s2_p_q[3*k+2];

        out_valid <= s3_vld_q;
        out_mode  <= s3_m_q;
        out_vcnt  <= s3_v_q;
        out_hcnt  <= s3_h_q;
        out_y     <= rnd_clip(s3_s_q[0], 1'b0);
        out_cb    <= rnd_clip(s3_s_q[1], 1'b1);
        out_cr    <= rnd_clip(s3_s_q[2], 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// tb_rgb2ycbcr_stream: directed vectors plus a random stream
// checked against an integer reference of the conversion.
module tb_rgb2ycbcr_stream;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_mode = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [8:0] in_vcnt = '0;
  logic [9:0] in_hcnt = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_y, out_cb, out_cr;
  logic [8:0] out_vcnt;
  logic [9:0] out_hcnt;
  logic       out_mode;

  rgb2ycbcr_stream dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .in_vcnt  (in_vcnt),
    .in_hcnt  (in_hcnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_cb   (out_cb),
    .out_cr   (out_cr),
    .out_vcnt (out_vcnt),
    .out_hcnt (out_hcnt),
    .out_mode (out_mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    int y, cb, cr, v, h, m;
  } px_t;

  px_t q [$];
  int  n_asrt = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_acc = 0;
  bit  tb_mode = 0;
  bit  prev_stall = 0;
  int  pv_y, pv_cb, pv_cr, pv_v, pv_h;

  int coefs [18] = '{
    218, 732, 74, -117, -395, 512, 512, -465, -47,
    306, 601, 117, -173, -339, 512, 512, -429, -83
  };

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int model(input int r, input int g, input int b,
                               input int k, input bit m);
    int base, s, t;
    base = (m ? 9 : 0) + 3 * k;
    s = r * coefs[base] + g * coefs[base+1] + b * coefs[base+2];
    t = ((s >>> 9) + 1) >>> 1;
    if (k != 0) t += 128;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t;
  endfunction

  // Scoreboard, hold check and model, all sampled on the falling edge.
  always @(negedge clock) begin
    px_t e;
    bit  m;
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
      tb_mode = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", int'(out_valid), 1);
        chk("hold_y", int'(out_y), pv_y);
        chk("hold_cb", int'(out_cb), pv_cb);
        chk("hold_cr", int'(out_cr), pv_cr);
        chk("hold_pos", int'(out_vcnt) * 1024 + int'(out_hcnt),
            pv_v * 1024 + pv_h);
      end
      prev_stall = out_valid && !out_ready;
      pv_y = out_y; pv_cb = out_cb; pv_cr = out_cr;
      pv_v = out_vcnt; pv_h = out_hcnt;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          e = q.pop_front();
          chk("sb_y", int'(out_y), e.y);
          chk("sb_cb", int'(out_cb), e.cb);
          chk("sb_cr", int'(out_cr), e.cr);
          chk("sb_v", int'(out_vcnt), e.v);
          chk("sb_h", int'(out_hcnt), e.h);
          chk("sb_m", int'(out_mode), e.m);
        end
      end
      if (in_valid && in_ready) begin
        m = (in_vcnt == 0 && in_hcnt == 0) ? in_mode : tb_mode;
        tb_mode = m;
        e.y  = model(in_r, in_g, in_b, 0, m);
        e.cb = model(in_r, in_g, in_b, 1, m);
        e.cr = model(in_r, in_g, in_b, 2, m);
        e.v = in_vcnt; e.h = in_hcnt; e.m = int'(m);
        q.push_back(e);
      end
    end
  end

  task automatic send(input int r, input int g, input int b,
                      input int v, input int h, input bit m);
    bit ok;
    ok = 0;
    @(posedge clock); #1;
    in_valid = 1; in_mode = m;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    in_vcnt = 9'(v); in_hcnt = 10'(h);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    last_acc = cyc;
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic expect_out(input string tag, input int y, input int cb,
                            input int cr, input int m, input int lat);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        seen = 1;
        chk({tag, "_y"}, int'(out_y), y);
        chk({tag, "_cb"}, int'(out_cb), cb);
        chk({tag, "_cr"}, int'(out_cr), cr);
        chk({tag, "_mode"}, int'(out_mode), m);
        if (lat >= 0) chk({tag, "_lat"}, cyc - last_acc, lat);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    out_ready = 1; in_valid = 0;
    for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++)
      @(negedge clock);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bit acc;
    int k, sent;

    #3;
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_rdy", int'(in_ready), 1);
    chk("rst_y", int'(out_y), 0);
    chk("rst_cb", int'(out_cb), 0);
    chk("rst_mode", int'(out_mode), 0);
    @(negedge clock); @(negedge clock);
    rst_n = 1;

    // in_mode is ignored away from (0,0): reset frame mode is BT.709
    send(255, 255, 255, 5, 5, 1);
    expect_out("white", 255, 128, 128, 0, 4);
    send(0, 0, 0, 5, 6, 1);
    expect_out("black", 0, 128, 128, 0, 4);
    send(255, 0, 0, 5, 7, 0);
    expect_out("red709", 54, 99, 255, 0, 4);
    send(0, 255, 0, 5, 8, 0);
    expect_out("grn709", 182, 30, 12, 0, 4);
    send(0, 0, 255, 5, 9, 0);
    expect_out("blu709", 18, 255, 116, 0, 4);

    send(0, 0, 0, 0, 0, 1);
    send(255, 0, 0, 0, 1, 0);
    expect_out("sof601", 0, 128, 128, 1, -1);
    expect_out("red601", 76, 85, 255, 1, -1);
    send(0, 0, 255, 0, 0, 0);
    expect_out("blu_back", 18, 255, 116, 0, -1);

    // Continuous stream with three blocked output cycles
    acc = 0; k = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (acc) k++;
      out_ready = !(i >= 6 && i < 9);
      in_valid = 1; in_mode = 0;
      in_r = 8'(k * 37); in_g = 8'(k * 91 + 5); in_b = 8'(k * 13);
      in_vcnt = 9'd1; in_hcnt = 10'(k + 1);
      @(negedge clock);
      if (!out_ready) begin
        chk("stall_rdy", int'(in_ready), 0);
        chk("stall_vld", int'(out_valid), 1);
      end
      acc = in_ready;
    end
    @(posedge clock); #1;
    in_valid = 0;
    drain();

    // Reset with pixels in flight and one blocked at the output
    out_ready = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_r = 8'(40 * i + 10); in_g = 8'(200 - i); in_b = 8'(i);
      in_vcnt = 9'd2; in_hcnt = 10'(i);
      @(posedge clock); #1;
    end
    in_valid = 0;
    @(posedge clock); #1;
    chk("pre_rst_vld", int'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_vld", int'(out_valid), 0);
    chk("mid_rst_y", int'(out_y), 0);
    chk("mid_rst_rdy", int'(in_ready), 1);
    @(negedge clock); @(negedge clock);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_rst_vld", int'(out_valid), 0);
    end
    send(0, 0, 255, 3, 3, 1);
    expect_out("post_rst", 18, 255, 116, 0, 4);

    // Random valid/ready stream with occasional start-of-frame beats
    sent = 0; acc = 0;
    while (sent < 10000) begin
      @(posedge clock); #1;
      if (acc) begin sent++; in_valid = 0; end
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        in_mode = 1'($urandom_range(0, 1));
        in_r = 8'($urandom_range(0, 255));
        in_g = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) begin
          in_vcnt = '0; in_hcnt = '0;
        end else begin
          in_vcnt = 9'($urandom_range(0, 479));
          in_hcnt = 10'($urandom_range(0, 639));
        end
      end
      @(negedge clock);
      acc = in_valid && in_ready;
    end
    @(posedge clock); #1;
    in_valid = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
